rf_pulse_monitor: RTL
=====================

// Module: rf_pulse_monitor
// PURPOSE
//  Receive-side checker for the RF gate line driven by the pulse sequencer (MZ pi/2-pi-pi/2 and Rabi trains).
//  Once armed, measures every high pulse and low gap on rf_in in clk cycles and queues {level,width} records
//  in a FWFT FIFO for the host MCU to read. Detects end-of-sequence by a low-level timeout.
// PARAMETERS
//  CNT_W       32      width of the width counter and of rd_width
//  FIFO_DEPTH  8       record FIFO depth (power of 2, >=2)
//  SYNC_STAGES 2       rf_in synchroniser flops (>=2)
//  TIMEOUT     200000  low cycles after last pulse that end the sequence
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      async active-low reset
//  rf_in       in   1      RF gate under test (asynchronous)
//  arm         in   1      1-cycle pulse: clear status, start waiting for first rising edge
//  rd_en       in   1      pop head record (ignored when fifo_empty)
//  rd_level    out  1      head record: 1 = high pulse, 0 = low gap
//  rd_width    out  CNT_W  head record: duration in clk cycles
//  fifo_empty  out  1      no record available
//  fifo_full   out  1      FIFO holds FIFO_DEPTH records
//  overflow    out  1      sticky: record dropped
//  busy        out  1      state is ARMED or MEASURE
//  seq_done    out  1      level: sequence ended by timeout, held until next arm
//  pulse_count out  8      rising edges seen this sequence, saturates at 255
// BEHAVIOUR
//  - Async reset (rst_n=0): state IDLE, all outputs 0 except fifo_empty=1; FIFO pointers, counter, sync flops cleared.
//  - rf_in passes SYNC_STAGES flops -> rf_s; rf_d = rf_s delayed 1; rise = rf_s&~rf_d, fall = ~rf_s&rf_d.
//  - States: IDLE -> (arm) ARMED -> (rise) MEASURE -> (timeout) DONE -> (arm) ARMED.
//  - arm in IDLE/DONE: FIFO flushed, overflow, seq_done, pulse_count cleared, go ARMED. arm in ARMED/MEASURE ignored.
//  - ARMED: edges other than rise ignored; rise -> MEASURE, cnt<=1, pulse_count<=1. Leading low time not recorded.
//  - MEASURE: each cycle without edge cnt<=cnt+1, saturating at 2^CNT_W-1.
//    On an edge: push {rd_level = previous level rf_d, width = cnt}; cnt<=1; rise also increments pulse_count (sat).
//    Timeout: rf_s low and cnt reaches TIMEOUT -> DONE, seq_done<=1; trailing gap NOT pushed.
//  - Width rule: an rf_in level stable N clock cycles yields width N exactly (sync delay common to both edges).
//  - Latency: rf_in edge meeting setup at edge k -> record visible (fifo_empty=0) after edge k+SYNC_STAGES+2.
//  - FIFO: first-word-fall-through; rd_level/rd_width valid whenever fifo_empty=0; rd_en pops at clock edge.
//    Push when full and no pop: record dropped, overflow<=1 (sticky until arm/reset).
//    Push and pop same cycle when full: both succeed, no overflow. Push/pop same cycle when empty: pop ignored, push succeeds.
//    rd_en while empty: no effect, pointers unchanged.
//  - Reset mid-MEASURE: immediate return to IDLE, partial count and FIFO contents discarded.
// TESTING
//  1 arm; rf_in low 50, high 333, low 1000, high 666, low 1000, high 333, low >TIMEOUT -> records
//    (1,333)(0,1000)(1,666)(0,1000)(1,333); pulse_count=3; seq_done=1 TIMEOUT cycles after last fall.
//  2 rf_in toggles before arm -> fifo_empty stays 1, pulse_count=0; after arm, first record is first high pulse.
//  3 no reads, 5 pulses (9 records) with FIFO_DEPTH=8 -> fifo_full=1, overflow=1, 8 oldest records intact in order.
//  4 full FIFO, rd_en held high during a new edge -> no overflow, record count stays 8, order preserved.
//  5 CNT_W=8, high 300 cycles -> record (1,255); next low gap measured correctly.
//  6 rst_n low during MEASURE with 3 records queued -> fifo_empty=1, busy=0, all status 0; re-arm works normally.

Source files
------------

// File: rtl/rf_pulse_monitor.sv
// rf_pulse_monitor
//   Receive-side checker for the RF gate line. Once armed, it measures every
//   high pulse and low gap on rf_in in clk cycles and queues {level,width}
//   records in a first-word-fall-through FIFO for the host to read. A low
//   level lasting TIMEOUT cycles ends the sequence.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   rf_in          RF gate under test (asynchronous to clk)
//   arm            1-cycle pulse: clear status, wait for the first rising edge
//   rd_en          pop the head record (ignored while fifo_empty)
//   rd_level       head record level (1 = high pulse, 0 = low gap)
//   rd_width       head record duration in clk cycles
//   fifo_empty     no record available
//   fifo_full      FIFO holds FIFO_DEPTH records
//   overflow       sticky: a record was dropped
//   busy           waiting for the first edge or measuring
//   seq_done       sequence ended by timeout, held until the next arm
//   pulse_count    rising edges seen this sequence, saturating at 255
module rf_pulse_monitor #(
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rf_in,
    input  logic             arm,
    input  logic             rd_en,
    output logic             rd_level,
    output logic [CNT_W-1:0] rd_width,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             overflow,
    output logic             busy,
    output logic             seq_done,
    output logic [7:0]       pulse_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // A timeout beyond the counter range can only be met at saturation.
    localparam logic [CNT_W-1:0] TO_C =
        (longint'(TIMEOUT) > longint'(CNT_MAX)) ? CNT_MAX : CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_DONE} state_t;

    // Synchroniser and edge detection. Edges are registered once so that the
    // FSM sees rise/fall from flops; both edges share the same delay, so a
    // level held N cycles still measures exactly N.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rf_s, rf_d_q, rise_q, fall_q;

    assign rf_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rf_d_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rf_in};
            rf_d_q <= rf_s;
            rise_q <= rf_s & ~rf_d_q;
            fall_q <= ~rf_s & rf_d_q;
        end
    end

    // Measurement FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, push_w_q, push_w_d;
    logic [7:0]       pc_q, pc_d;
    logic             lvl_q, lvl_d, done_q, done_d;
    logic             push_q, push_d, push_lvl_q, push_lvl_d;
    logic             flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        lvl_d      = lvl_q;
        done_d     = done_q;
        push_d     = 1'b0;
        push_lvl_d = push_lvl_q;
        push_w_d   = push_w_q;
        flush      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    flush   = 1'b1;
                    done_d  = 1'b0;
                    pc_d    = '0;
                end
            end
            S_ARMED: begin
                // Leading low time is not recorded.
                if (rise_q) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_W'(1);
                    pc_d    = 8'd1;
                    lvl_d   = 1'b1;
                end
            end
            S_MEASURE: begin
                if (rise_q || fall_q) begin
                    // Close the segment that just ended.
                    push_d     = 1'b1;
                    push_lvl_d = lvl_q;
                    push_w_d   = cnt_q;
                    cnt_d      = CNT_W'(1);
                    lvl_d      = rise_q;
                    if (rise_q && pc_q != 8'hFF) pc_d = pc_q + 8'd1;
                end else if (!lvl_q && cnt_q >= TO_C) begin
                    // Trailing gap is dropped.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pc_q       <= '0;
            lvl_q      <= 1'b0;
            done_q     <= 1'b0;
            push_q     <= 1'b0;
            push_lvl_q <= 1'b0;
            push_w_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            lvl_q      <= lvl_d;
            done_q     <= done_d;
            push_q     <= push_d;
            push_lvl_q <= push_lvl_d;
            push_w_q   <= push_w_d;
        end
    end

    // Record FIFO: pointers carry one wrap bit to tell full from empty.
    logic [AW:0]      wp_q, rp_q;
    logic             lvl_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] w_mem   [FIFO_DEPTH];
    logic             empty, full, pop, wr, ovf_q;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop   = rd_en & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr    = push_q & ~flush & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr)  wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            if (push_q && !wr) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            lvl_mem[wp_q[AW-1:0]] <= push_lvl_q;
            w_mem[wp_q[AW-1:0]]   <= push_w_q;
        end
    end

    // Head is forced to zero while empty so outputs are defined out of reset.
    assign rd_level    = ~empty & lvl_mem[rp_q[AW-1:0]];
    assign rd_width    = empty ? '0 : w_mem[rp_q[AW-1:0]];
    assign fifo_empty  = empty;
    assign fifo_full   = full;
    assign overflow    = ovf_q;
    assign busy        = (state_q == S_ARMED) || (state_q == S_MEASURE);
    assign seq_done    = done_q;
    assign pulse_count = pc_q;

endmodule
